// File: rtl/wb_arbiter_if.sv
// Result-port bundle between the execution units and the writeback arbiter,
// plus the shared condition/exception flag type.
package wb_arbiter_pkg;
  typedef struct packed {
    logic ov;
    logic ov_valid;
    logic ca;
    logic ca_valid;
    logic cr0_valid;
  } cond_exception_t;
endpackage

interface wb_arbiter_if
  import wb_arbiter_pkg::*;
#(
  parameter int RS_ID_WIDTH = 5,
  parameter int NUM_UNITS   = 4
);
  logic [0:NUM_UNITS-1]                  unit_valid;
  logic [0:NUM_UNITS-1]                  unit_ready;
  logic [0:NUM_UNITS-1][0:RS_ID_WIDTH-1] unit_rs_id;
  logic [0:NUM_UNITS-1][0:4]             unit_reg_addr;
  logic [0:NUM_UNITS-1][0:31]            unit_result;
  cond_exception_t [0:NUM_UNITS-1]       unit_cr0_xer;
  logic                                  so_clear;
  logic                                  wb_valid;
  logic                                  wb_ready;
  logic [0:RS_ID_WIDTH-1]                wb_rs_id;
  logic [0:4]                            wb_reg_addr;
  logic [0:31]                           wb_result;
  logic [0:3]                            wb_cr0;
  logic                                  wb_cr0_valid;
  logic                                  wb_ov;
  logic                                  wb_ov_valid;
  logic                                  wb_ca;
  logic                                  wb_ca_valid;
  logic                                  wb_so;

  modport master (
    output unit_valid, unit_rs_id, unit_reg_addr,
    output unit_result, unit_cr0_xer, so_clear, wb_ready,
    input  unit_ready, wb_valid, wb_rs_id, wb_reg_addr,
    input  wb_result, wb_cr0, wb_cr0_valid, wb_ov,
    input  wb_ov_valid, wb_ca, wb_ca_valid, wb_so
  );

  modport slave (
    input  unit_valid, unit_rs_id, unit_reg_addr,
    input  unit_result, unit_cr0_xer, so_clear, wb_ready,
    output unit_ready, wb_valid, wb_rs_id, wb_reg_addr,
    output wb_result, wb_cr0, wb_cr0_valid, wb_ov,
    output wb_ov_valid, wb_ca, wb_ca_valid, wb_so
  );
endinterface

// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter: picks one execution-unit result per free
// slot, registers it onto the writeback bus and tracks sticky XER[SO].
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int RS_ID_WIDTH = 5,
  parameter int NUM_UNITS   = 4
) (
  input logic       clk,
  input logic       rst,
  wb_arbiter_if.slave bus
);
  localparam int PW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  function automatic logic [PW-1:0] wrap(input int v);
    return PW'(v % NUM_UNITS);
  endfunction

  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   cand;
  logic [PW-1:0]   gnt_idx;
  logic            found;
  logic            free;
  logic            grant;
  logic            so_ff;
  logic            so_nxt;
  logic [31:0]     res;
  cond_exception_t sel;

  assign free = !bus.wb_valid || bus.wb_ready;

  // Only valid/ptr/slot state feed the grant; data fields never do.
  always_comb begin
    cand    = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      cand = wrap(int'(rr_ptr) + k);
      if (!found && bus.unit_valid[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign grant = found && free && !rst;

  always_comb begin
    bus.unit_ready = '0;
    if (grant)
      bus.unit_ready[gnt_idx] = 1'b1;
  end

  assign res = bus.unit_result[gnt_idx];
  assign sel = bus.unit_cr0_xer[gnt_idx];

  // Set from an accepted overflow beats a same-cycle clear.
  assign so_nxt = (so_ff & ~bus.so_clear)
                | (grant & sel.ov_valid & sel.ov);

  assign bus.wb_so = so_ff;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr           <= '0;
      so_ff            <= 1'b0;
      bus.wb_valid     <= 1'b0;
      bus.wb_rs_id     <= '0;
      bus.wb_reg_addr  <= '0;
      bus.wb_result    <= '0;
      bus.wb_cr0       <= '0;
      bus.wb_cr0_valid <= 1'b0;
      bus.wb_ov        <= 1'b0;
      bus.wb_ov_valid  <= 1'b0;
      bus.wb_ca        <= 1'b0;
      bus.wb_ca_valid  <= 1'b0;
    end else begin
      so_ff <= so_nxt;
      if (grant)
        rr_ptr <= wrap(int'(gnt_idx) + 1);
      if (free)
        bus.wb_valid <= grant;
      if (grant) begin
        bus.wb_rs_id     <= bus.unit_rs_id[gnt_idx];
        bus.wb_reg_addr  <= bus.unit_reg_addr[gnt_idx];
        bus.wb_result    <= res;
        bus.wb_cr0       <= {res[31],
                             ~res[31] & (|res),
                             ~(|res),
                             so_nxt};
        bus.wb_cr0_valid <= sel.cr0_valid;
        bus.wb_ov        <= sel.ov;
        bus.wb_ov_valid  <= sel.ov_valid;
        bus.wb_ca        <= sel.ca;
        bus.wb_ca_valid  <= sel.ca_valid;
      end
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed and randomised checks of wb_arbiter against a behavioural
// writeback model with round-robin fairness tracking.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int RW = 5;
  localparam int N  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  wb_arbiter_if #(.RS_ID_WIDTH(RW), .NUM_UNITS(N)) intf ();

  wb_arbiter #(.RS_ID_WIDTH(RW), .NUM_UNITS(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (intf.slave)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Behavioural model: what the bus must show after the next edge.
  int              m_next;
  logic            m_valid = 1'b0;
  logic            m_so = 1'b0;
  logic [RW-1:0]   m_id = '0;
  logic [4:0]      m_addr = '0;
  logic [31:0]     m_res = '0;
  logic [3:0]      m_cr0 = '0;
  logic [4:0]      m_flags = '0;
  int              waits [N];

  initial begin
    m_next = 0;
    for (int i = 0; i < N; i++) waits[i] = 0;
  end

  always @(negedge clk) begin
    int              g;
    logic            slot;
    logic [0:N-1]    er;
    logic [31:0]     r;
    cond_exception_t x;
    logic            sn;
    g    = -1;
    slot = !m_valid || intf.wb_ready;
    if (!rst && slot)
      for (int d = N - 1; d >= 0; d--)
        if (intf.unit_valid[(m_next + d) % N])
          g = (m_next + d) % N;
    er = '0;
    if (g >= 0) er[g] = 1'b1;

    chk("unit_ready", intf.unit_ready, er);
    chk("wb_valid", intf.wb_valid, m_valid);
    chk("wb_so", intf.wb_so, m_so);
    if (m_valid) begin
      chk("wb_rs_id", intf.wb_rs_id, m_id);
      chk("wb_reg_addr", intf.wb_reg_addr, m_addr);
      chk("wb_result", intf.wb_result, m_res);
      chk("wb_cr0", intf.wb_cr0, m_cr0);
      chk("wb_flags", {intf.wb_ov, intf.wb_ov_valid, intf.wb_ca,
                       intf.wb_ca_valid, intf.wb_cr0_valid}, m_flags);
    end

    for (int u = 0; u < N; u++) begin
      if (rst || !intf.unit_valid[u] || g == u) waits[u] = 0;
      else if (slot) waits[u]++;
      chk("starve", waits[u] >= N, 1'b0);
    end

    if (rst) begin
      m_valid = 1'b0;
      m_so    = 1'b0;
      m_next  = 0;
    end else begin
      x  = (g >= 0) ? intf.unit_cr0_xer[g] : '0;
      sn = (m_so && !intf.so_clear) || (g >= 0 && x.ov_valid && x.ov);
      m_so = sn;
      if (slot) m_valid = (g >= 0);
      if (g >= 0) begin
        r       = intf.unit_result[g];
        m_next  = (g + 1) % N;
        m_id    = intf.unit_rs_id[g];
        m_addr  = intf.unit_reg_addr[g];
        m_res   = r;
        m_cr0   = {$signed(r) < 0, $signed(r) > 0, r == 0, sn};
        m_flags = {x.ov, x.ov_valid, x.ca, x.ca_valid, x.cr0_valid};
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    intf.unit_valid    = '0;
    intf.unit_rs_id    = '0;
    intf.unit_reg_addr = '0;
    intf.unit_result   = '0;
    intf.unit_cr0_xer  = '0;
    intf.so_clear      = 1'b0;
  endtask

  logic [3:0]    exp_gnt [5];
  logic [RW-1:0] exp_id [5];

  initial begin
    exp_gnt = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
    exp_id  = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd1};
    idle();
    intf.wb_ready = 1'b1;
    intf.unit_valid = '1;
    tick();
    @(negedge clk);
    chk("rst_ready", intf.unit_ready, 4'b0000);
    chk("rst_valid", intf.wb_valid, 1'b0);
    chk("rst_so", intf.wb_so, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Round-robin sweep with every unit requesting.
    for (int u = 0; u < N; u++) begin
      intf.unit_rs_id[u]    = RW'(u + 1);
      intf.unit_reg_addr[u] = 5'(u + 8);
      intf.unit_result[u]   = 32'(u * 100);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("rr_grant", intf.unit_ready, exp_gnt[c]);
      if (c > 0) chk("rr_id", intf.wb_rs_id, exp_id[c-1]);
      @(posedge clk); #1;
    end
    idle();
    tick(); tick();

    // Held result under back-pressure.
    intf.wb_ready = 1'b0;
    intf.unit_valid[2] = 1'b1;
    intf.unit_result[2] = 32'hFFFF_FFF0;
    intf.unit_cr0_xer[2].cr0_valid = 1'b1;
    tick();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("hold_valid", intf.wb_valid, 1'b1);
      chk("hold_cr0", intf.wb_cr0, 4'b1000);
      chk("hold_ready", intf.unit_ready, 4'b0000);
      @(posedge clk); #1;
    end
    intf.wb_ready = 1'b1;
    @(negedge clk);
    chk("release_ready", intf.unit_ready, 4'b0010);
    @(posedge clk); #1;
    idle();
    tick();

    // Overflow sets SO; zero result; positive result keeps SO.
    intf.unit_valid[1] = 1'b1;
    intf.unit_result[1] = 32'd0;
    intf.unit_cr0_xer[1] = '{ov:1'b1, ov_valid:1'b1, ca:1'b0,
                             ca_valid:1'b0, cr0_valid:1'b1};
    tick();
    intf.unit_result[1] = 32'd5;
    intf.unit_cr0_xer[1] = '{ov:1'b0, ov_valid:1'b0, ca:1'b1,
                             ca_valid:1'b1, cr0_valid:1'b1};
    @(negedge clk);
    chk("ov_cr0", intf.wb_cr0, 4'b0011);
    chk("ov_so", intf.wb_so, 1'b1);
    @(posedge clk); #1;
    idle();
    intf.so_clear = 1'b1;
    @(negedge clk);
    chk("pos_cr0", intf.wb_cr0, 4'b0101);
    @(posedge clk); #1;
    intf.so_clear = 1'b0;
    @(negedge clk);
    chk("clear_so", intf.wb_so, 1'b0);
    @(posedge clk); #1;

    // Clear and set in the same cycle: set wins.
    intf.unit_valid[0] = 1'b1;
    intf.unit_result[0] = 32'd7;
    intf.unit_cr0_xer[0] = '{ov:1'b1, ov_valid:1'b1, ca:1'b0,
                             ca_valid:1'b0, cr0_valid:1'b1};
    intf.so_clear = 1'b1;
    tick();
    idle();
    @(negedge clk);
    chk("race_so", intf.wb_so, 1'b1);
    chk("race_cr0", intf.wb_cr0, 4'b0101);
    @(posedge clk); #1;
    intf.so_clear = 1'b1;
    tick();
    idle();

    // Reset while a result is held.
    intf.wb_ready = 1'b0;
    intf.unit_valid[0] = 1'b1;
    tick();
    idle();
    @(negedge clk);
    chk("pre_rst_valid", intf.wb_valid, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", intf.wb_valid, 1'b0);
    @(posedge clk); #1;
    intf.wb_ready = 1'b1;
    intf.unit_valid[3] = 1'b1;
    intf.unit_reg_addr[3] = 5'd17;
    @(negedge clk);
    chk("u3_ready", intf.unit_ready, 4'b0001);
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    chk("u3_addr", intf.wb_reg_addr, 5'd17);
    @(posedge clk); #1;

    // Randomised traffic checked by the model.
    for (int c = 0; c < 4000; c++) begin
      for (int u = 0; u < N; u++) begin
        intf.unit_valid[u]    = ($urandom_range(0, 2) != 0);
        intf.unit_rs_id[u]    = RW'($urandom);
        intf.unit_reg_addr[u] = 5'($urandom);
        intf.unit_result[u]   = ($urandom_range(0, 7) == 0) ? 32'd0
                                                            : $urandom;
        intf.unit_cr0_xer[u]  = 5'($urandom);
      end
      intf.so_clear = ($urandom_range(0, 9) == 0);
      intf.wb_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0;
    idle();
    intf.wb_ready = 1'b1;
    tick(); tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
